heartbeat_pulse_gen: RTL and testbench

//  Consumes the 2-bit rate class from heartbeat_model and renders it as a timed
//  "lub-dub" beat waveform for the LED/output pin, plus a beat-start strobe and

---
 rtl/heartbeat_pulse_gen.sv | 77 +++++++
 tb/tb_heartbeat_pulse_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/heartbeat_pulse_gen.sv
// heartbeat_pulse_gen: renders a latched rate class as a timed lub-dub beat waveform with strobe and counter
module heartbeat_pulse_gen #(
  parameter int CNT_W   = 10,
  parameter int PERIOD0 = 1000,
  parameter int PERIOD1 = 750,
  parameter int PERIOD2 = 500,
  parameter int PERIOD3 = 300,
  parameter int LUB_LEN = 60,
  parameter int GAP_LEN = 60,
  parameter int DUB_LEN = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tick,
  input  logic [1:0] heartbeat,
  output logic       beat,
  output logic       beat_start,
  output logic [7:0] beat_count,
  output logic [1:0] rate_latched
);
  typedef enum logic [2:0] {IDLE, LUB, GAP, DUB, REST} state_t;
  localparam int BODY = LUB_LEN + GAP_LEN + DUB_LEN;
  localparam bit LEGAL = PERIOD0 > BODY && PERIOD1 > BODY && PERIOD2 > BODY && PERIOD3 > BODY &&
                         LUB_LEN >= 1 && GAP_LEN >= 1 && DUB_LEN >= 1;
  localparam logic [CNT_W-1:0] LUB_M1 = CNT_W'(LUB_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] DUB_M1 = CNT_W'(DUB_LEN - 1);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_n, rest_m1;
  logic enter;
  // REST length follows the class latched at the start of this beat, never the live input
  always_comb rest_m1 = rate_latched == 2'd0 ? CNT_W'(PERIOD0 - BODY - 1) :
                        rate_latched == 2'd1 ? CNT_W'(PERIOD1 - BODY - 1) :
                        rate_latched == 2'd2 ? CNT_W'(PERIOD2 - BODY - 1) :
                                               CNT_W'(PERIOD3 - BODY - 1);
  always_comb begin
    nxt = state;
    cnt_n = cnt;
    enter = 1'b0;
    if (!enable) begin
      nxt = IDLE;
      cnt_n = '0;
    end else if (state == IDLE) begin
      nxt = LUB;
      cnt_n = LUB_M1;
      enter = 1'b1;
    end else if (tick) begin
      if (cnt != '0) cnt_n = cnt - 1'b1;
      else begin
        nxt = state == LUB ? GAP : state == GAP ? DUB : state == DUB ? REST : LUB;
        cnt_n = state == LUB ? GAP_M1 : state == GAP ? DUB_M1 : state == DUB ? rest_m1 : LUB_M1;
        enter = state == REST;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (LEGAL);
      state <= IDLE;
      cnt <= '0;
      beat <= 1'b0;
      beat_start <= 1'b0;
      beat_count <= '0;
      rate_latched <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      beat <= nxt == LUB || nxt == DUB;
      beat_start <= enter;
      if (enter) begin
        beat_count <= beat_count + 1'b1;
        rate_latched <= heartbeat;
      end
    end
  end
endmodule

// File: tb/tb_heartbeat_pulse_gen.sv
// tb_heartbeat_pulse_gen: directed vectors and beat-shape sequences for heartbeat_pulse_gen
module tb_heartbeat_pulse_gen;
  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, tick = 1'b0;
  logic [1:0] heartbeat = 2'd0;
  logic beat, beat_start;
  logic [7:0] beat_count;
  logic [1:0] rate_latched;
  logic rst2 = 1'b1, en2 = 1'b0, tick2 = 1'b0;
  logic [1:0] hb2 = 2'd0;
  logic beat2, start2;
  logic [7:0] count2;
  logic [1:0] rate2;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  heartbeat_pulse_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .tick(tick), .heartbeat(heartbeat),
    .beat(beat), .beat_start(beat_start), .beat_count(beat_count), .rate_latched(rate_latched)
  );

  heartbeat_pulse_gen #(.CNT_W(4), .PERIOD0(8), .PERIOD1(8), .PERIOD2(8), .PERIOD3(8),
                        .LUB_LEN(2), .GAP_LEN(1), .DUB_LEN(1)) dut2 (
    .clk(clk), .rst(rst2), .enable(en2), .tick(tick2), .heartbeat(hb2),
    .beat(beat2), .beat_start(start2), .beat_count(count2), .rate_latched(rate2)
  );

  typedef struct {
    logic r, en, tk;
    logic [1:0] hb;
    logic e_beat, e_start;
    logic [7:0] e_count;
    logic [1:0] e_rate;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic bit exp_beat(input int p);
    return p < 60 || (p >= 120 && p < 160);
  endfunction

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 2'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 2'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 2'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 8'd1, 2'd2};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 8'd1, 2'd2};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 8'd1, 2'd2};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd1, 2'd2};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 8'd2, 2'd3};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0, 2'd0};
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].r;
      enable = vecs[i].en;
      tick = vecs[i].tk;
      heartbeat = vecs[i].hb;
      step();
      chk($sformatf("vec%0d beat", i), beat, vecs[i].e_beat);
      chk($sformatf("vec%0d beat_start", i), beat_start, vecs[i].e_start);
      chk($sformatf("vec%0d beat_count", i), beat_count, vecs[i].e_count);
      chk($sformatf("vec%0d rate_latched", i), rate_latched, vecs[i].e_rate);
    end

    // class 3, tick tied high: 300-cycle beats
    do_reset();
    heartbeat = 2'd3;
    tick = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 600; k++) begin
      step();
      chk("c3 beat", beat, exp_beat(k % 300));
      chk("c3 beat_start", beat_start, (k % 300) == 0);
    end

    // class 0, tick every 4th cycle: 4000-cycle beats
    do_reset();
    heartbeat = 2'd0;
    enable = 1'b1;
    for (int k = 0; k <= 8000; k++) begin
      tick = (k % 4) == 0;
      step();
      chk("c0 beat", beat, exp_beat((k % 4000) / 4));
      chk("c0 beat_start", beat_start, (k % 4000) == 0);
    end

    // class change during GAP takes effect only at the next beat
    do_reset();
    heartbeat = 2'd0;
    tick = 1'b1;
    enable = 1'b1;
    for (int k = 0; k <= 1300; k++) begin
      if (k == 90) heartbeat = 2'd3;
      step();
      chk("chg beat", beat, exp_beat(k < 1000 ? k : (k - 1000) % 300));
      chk("chg beat_start", beat_start, k == 0 || k == 1000 || k == 1300);
      chk("chg rate_latched", rate_latched, k < 1000 ? 0 : 3);
    end

    // enable drop during DUB, then restart
    do_reset();
    heartbeat = 2'd3;
    tick = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 130; k++) step();
    chk("dub beat high", beat, 1);
    enable = 1'b0;
    step();
    chk("dis beat", beat, 0);
    chk("dis beat_count", beat_count, 1);
    chk("dis rate_latched", rate_latched, 3);
    step();
    chk("dis idle beat", beat, 0);
    chk("dis idle start", beat_start, 0);
    enable = 1'b1;
    step();
    chk("reen beat", beat, 1);
    chk("reen beat_start", beat_start, 1);
    chk("reen beat_count", beat_count, 2);

    // 256 short beats wrap the counter; reset mid-LUB clears everything
    rst2 = 1'b1;
    step();
    step();
    rst2 = 1'b0;
    tick2 = 1'b1;
    en2 = 1'b1;
    for (int k = 0; k < 2040; k++) begin
      step();
      if (k == 0) chk("wrap first count", count2, 1);
      if (k == 2039) chk("wrap count 255", count2, 255);
    end
    step();
    chk("wrap count 0", count2, 0);
    chk("wrap start", start2, 1);
    chk("wrap beat", beat2, 1);
    rst2 = 1'b1;
    step();
    chk("rst2 beat", beat2, 0);
    chk("rst2 start", start2, 0);
    chk("rst2 count", count2, 0);
    chk("rst2 rate", rate2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
